// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell reused for WIDTH cycles,
// with operand shift registers, a carry flip-flop and a start/done handshake.

module fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (p & ci);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_n;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_s;
    logic             fa_c;
    logic             load;

    fa u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // res_sr keeps only the bits still needed; the newest sum bit completes the word
    assign res_n = {fa_s, res_sr};
    assign load  = start && (state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (cnt == LAST) state_n = FIN;
            FIN:     state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_n[WIDTH-1:1];
            carry  <= fa_c;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) begin
                sum_q  <= res_n;
                cout_q <= fa_c;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: vector table plus ignored-start,
// back-to-back and mid-operation reset sequences.

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks;
    int failures;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        string        name;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v);
        int unsigned n;
        int unsigned overlap;
        int unsigned idle_busy;
        logic        seen;
        start = 1'b1;
        sub   = v.sub;
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
        tick();
        start = 1'b0;
        a     = ~v.a;
        b     = ~v.b;
        cin   = ~v.cin;
        chk({v.name, "_busy"}, 32'(busy), 32'd1);
        n = 0; overlap = 0; idle_busy = 0; seen = 1'b0;
        while (!seen && n < 4 * W) begin
            tick();
            n++;
            if (busy && done) overlap++;
            if (done) seen = 1'b1;
            else if (!busy) idle_busy++;
        end
        chk({v.name, "_latency"}, n, W);
        chk({v.name, "_overlap"}, overlap, 0);
        chk({v.name, "_busy_gap"}, idle_busy, 0);
        chk({v.name, "_sum"}, 32'(sum), 32'(v.exp_sum));
        chk({v.name, "_cout"}, 32'(cout), 32'(v.exp_cout));
        tick();
        chk({v.name, "_done_pulse"}, 32'(done), 32'd0);
        chk({v.name, "_sum_hold"}, 32'(sum), 32'(v.exp_sum));
    endtask

    initial begin
        vec_t v;
        int   n;
        logic seen;

        checks = 0;
        failures = 0;

        vecs[0] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "add_0_0"};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01"};
        vecs[2] = '{1'b0, 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, "add_5a_a5_c"};
        vecs[3] = '{1'b1, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, "sub_10_01"};
        vecs[4] = '{1'b1, 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, "sub_01_02"};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "add_80_80"};
        vecs[6] = '{1'b1, 8'h55, 8'h55, 1'b0, 8'h00, 1'b1, "sub_55_55"};
        vecs[7] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, "add_12_34_c"};
        vecs[8] = '{1'b1, 8'h00, 8'hFF, 1'b0, 8'h01, 1'b0, "sub_00_ff"};
        vecs[9] = '{1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "add_03_04"};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i]);
            tick();
        end

        // Start pulses during RUN with different operands are ignored
        start = 1'b1; sub = 1'b0; a = 8'h03; b = 8'h04; cin = 1'b0;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= W; i++) begin
            start = (i == 2 || i == 5);
            a = 8'hFF; b = 8'hFF; cin = 1'b1;
            tick();
            if (i < W && done) seen = 1'b1;
        end
        start = 1'b0;
        chk("ign_early_done", 32'(seen), 32'd0);
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_sum", 32'(sum), 32'h07);
        chk("ign_cout", 32'(cout), 32'd0);

        // Back-to-back: start during FIN is accepted immediately
        start = 1'b1; a = 8'h20; b = 8'h22; cin = 1'b0; sub = 1'b0;
        tick();
        start = 1'b0; a = 8'h00; b = 8'h00;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done_low", 32'(done), 32'd0);
        chk("b2b_hold_sum", 32'(sum), 32'h07);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 4 * W) begin
            tick();
            n++;
            if (done) seen = 1'b1;
            else if (sum !== 8'h07) seen = 1'b0;
        end
        chk("b2b_latency", n, W);
        chk("b2b_sum", 32'(sum), 32'h42);
        chk("b2b_cout", 32'(cout), 32'd0);
        tick();

        // Asynchronous reset in the middle of RUN discards the operation
        v = '{1'b0, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, "rst_mid"};
        start = 1'b1; sub = v.sub; a = v.a; b = v.b; cin = v.cin;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_sum", 32'(sum), 32'd0);
        chk("mid_cout", 32'(cout), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        chk("mid_no_done", 32'(seen), 32'd0);
        run_op('{1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post_rst"});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
